// File: rtl/if_fetch_stage.sv
// Purpose : instruction-fetch stage; owns the PC, reads imem and loads the IF/ID register.
// Latency : imem_addr is the PC combinationally; IF/ID fields appear one clock after imem_rdata.
// Backpr. : stall holds PC and IF/ID; redirect flushes with a bubble; halt freezes fetch until reset.
//
// Ports:
//    clk, reset          - single clock, synchronous active-high reset
//    stall               - load-use hold from hazard detection
//    redirect/_pc        - taken branch/jal/jalr target from EX (low two bits ignored)
//    halt                - Halt bit of ID/EX; stops fetch permanently until reset
//    imem_addr/_rdata    - combinational instruction-memory read port
//    ifid_*              - IF/ID register fields (curr_pc, curr_instr, valid)
//    halted              - fetch is stopped
//    fetch_cnt/bubble_cnt- saturating perf counters, present only with IF_FETCH_PERF_CNT_EN,
//                          otherwise tied to zero
module if_fetch_stage #(
   parameter int          PC_W     = 9,
   parameter int          INSTR_W  = 32,
   parameter int unsigned RESET_PC = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   input  logic               halt,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [PC_W-1:0]    ifid_curr_pc,
   output logic [INSTR_W-1:0] ifid_curr_instr,
   output logic               ifid_valid,
   output logic               halted,
   output logic [31:0]        fetch_cnt,
   output logic [31:0]        bubble_cnt
);

   // addi x0,x0,0 is what ID sees while IF/ID holds a bubble
   localparam logic [INSTR_W-1:0] BUBBLE_INSTR = INSTR_W'(32'h0000_0013);

   typedef enum logic {ST_RUN, ST_HALTED} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [PC_W-1:0]      r_pc;
   logic [PC_W-1:0]      w_pc_nxt;
   logic [PC_W-1:0]      r_ifid_pc;
   logic [PC_W-1:0]      w_ifid_pc_nxt;
   logic [INSTR_W-1:0]   r_ifid_instr;
   logic [INSTR_W-1:0]   w_ifid_instr_nxt;
   logic                 r_ifid_valid;
   logic                 w_ifid_valid_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_RUN;
         r_pc         <= PC_W'(RESET_PC);
         r_ifid_pc    <= '0;
         r_ifid_instr <= BUBBLE_INSTR;
         r_ifid_valid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_ifid_pc    <= w_ifid_pc_nxt;
         r_ifid_instr <= w_ifid_instr_nxt;
         r_ifid_valid <= w_ifid_valid_nxt;
      end
   end

   // Priority inside RUN: halt > redirect > stall > normal fetch.
   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_ifid_pc_nxt    = r_ifid_pc;
      w_ifid_instr_nxt = r_ifid_instr;
      w_ifid_valid_nxt = r_ifid_valid;
      case (r_state)
         ST_RUN: begin
            if (halt) begin
               w_state_nxt      = ST_HALTED;
               w_ifid_pc_nxt    = '0;
               w_ifid_instr_nxt = BUBBLE_INSTR;
               w_ifid_valid_nxt = 1'b0;
            end else if (redirect) begin
               // targets are word aligned; drop the byte offset
               w_pc_nxt         = {redirect_pc[PC_W-1:2], 2'b00};
               w_ifid_pc_nxt    = '0;
               w_ifid_instr_nxt = BUBBLE_INSTR;
               w_ifid_valid_nxt = 1'b0;
            end else if (!stall) begin
               // PC wraps silently at the top of the address space
               w_pc_nxt         = r_pc + PC_W'(4);
               w_ifid_pc_nxt    = r_pc;
               w_ifid_instr_nxt = imem_rdata;
               w_ifid_valid_nxt = 1'b1;
            end
         end
         default: begin
            w_ifid_pc_nxt    = '0;
            w_ifid_instr_nxt = BUBBLE_INSTR;
            w_ifid_valid_nxt = 1'b0;
         end
      endcase
   end

   assign imem_addr       = r_pc;
   assign ifid_curr_pc    = r_ifid_pc;
   assign ifid_curr_instr = r_ifid_instr;
   assign ifid_valid      = r_ifid_valid;
   assign halted          = (r_state == ST_HALTED);

`ifdef IF_FETCH_PERF_CNT_EN
   logic        w_run;
   logic        w_cnt_fetch;
   logic        w_cnt_bubble;
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_bubble_cnt;

   assign w_run        = (r_state == ST_RUN);
   assign w_cnt_fetch  = w_run && !halt && !redirect && !stall;
   assign w_cnt_bubble = w_run && (halt || redirect);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (w_cnt_fetch && (r_fetch_cnt != 32'hFFFF_FFFF))
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
         if (w_cnt_bubble && (r_bubble_cnt != 32'hFFFF_FFFF))
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
   end

   assign fetch_cnt  = r_fetch_cnt;
   assign bubble_cnt = r_bubble_cnt;
`else
   assign fetch_cnt  = 32'd0;
   assign bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

   localparam int PC_W    = 9;
   localparam int INSTR_W = 32;

   logic               clk = 1'b0;
   logic               reset;
   logic               stall;
   logic               redirect;
   logic [PC_W-1:0]    redirect_pc;
   logic               halt;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic [PC_W-1:0]    ifid_curr_pc;
   logic [INSTR_W-1:0] ifid_curr_instr;
   logic               ifid_valid;
   logic               halted;
   logic [31:0]        fetch_cnt;
   logic [31:0]        bubble_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // instruction memory: word at byte address A reads 0xA0 + A
   assign imem_rdata = 32'h0000_00A0 + 32'(imem_addr);

   if_fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(0)) dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .halt            (halt),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .ifid_curr_pc    (ifid_curr_pc),
      .ifid_curr_instr (ifid_curr_instr),
      .ifid_valid      (ifid_valid),
      .halted          (halted),
      .fetch_cnt       (fetch_cnt),
      .bubble_cnt      (bubble_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference ----------------
   // Architectural view: a PC, a stopped flag, the IF/ID contents and two counters.
   int unsigned m_pc;
   bit          m_stopped;
   int unsigned m_ipc;
   int unsigned m_iinstr;
   bit          m_ivld;
   longint      m_fc;
   longint      m_bc;
   bit          m_known = 1'b0;

   function automatic longint sat_inc(input longint v);
      return (v >= 64'hFFFF_FFFF) ? v : v + 1;
   endfunction

   always @(posedge clk) begin
      int kind;  // 0 reset, 1 frozen, 2 halt, 3 redirect, 4 stall, 5 fetch
      if (reset)             kind = 0;
      else if (m_stopped)    kind = 1;
      else if (halt)         kind = 2;
      else if (redirect)     kind = 3;
      else if (stall)        kind = 4;
      else                   kind = 5;
      case (kind)
         0: begin
            m_pc = 0; m_stopped = 0; m_fc = 0; m_bc = 0;
            m_ipc = 0; m_iinstr = 32'h13; m_ivld = 0;
            m_known = 1'b1;
         end
         1: begin m_ipc = 0; m_iinstr = 32'h13; m_ivld = 0; end
         2: begin
            m_stopped = 1; m_ipc = 0; m_iinstr = 32'h13; m_ivld = 0; m_bc = sat_inc(m_bc);
         end
         3: begin
            m_pc = (int'(redirect_pc) / 4) * 4;
            m_ipc = 0; m_iinstr = 32'h13; m_ivld = 0; m_bc = sat_inc(m_bc);
         end
         4: ;
         default: begin
            m_ipc = m_pc; m_iinstr = 32'hA0 + m_pc; m_ivld = 1;
            m_pc = (m_pc + 4) % (1 << PC_W);
            m_fc = sat_inc(m_fc);
         end
      endcase
   end

   // ---------------- per-cycle comparison ----------------
   always @(negedge clk) begin
      if (m_known) begin
         chk("imem_addr",  32'(imem_addr),    m_pc);
         chk("ifid_pc",    32'(ifid_curr_pc), m_ipc);
         chk("ifid_instr", ifid_curr_instr,   m_iinstr);
         chk("ifid_valid", 32'(ifid_valid),   32'(m_ivld));
         chk("halted",     32'(halted),       32'(m_stopped));
`ifdef IF_FETCH_PERF_CNT_EN
         chk("fetch_cnt",  fetch_cnt,  32'(m_fc));
         chk("bubble_cnt", bubble_cnt, 32'(m_bc));
`else
         chk("fetch_cnt",  fetch_cnt,  32'd0);
         chk("bubble_cnt", bubble_cnt, 32'd0);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
      tick(); tick();
      chk("rst_addr",   32'(imem_addr),  32'h0);
      chk("rst_valid",  32'(ifid_valid), 32'h0);
      chk("rst_instr",  ifid_curr_instr, 32'h13);
      chk("rst_halted", 32'(halted),     32'h0);
      chk("rst_fcnt",   fetch_cnt,       32'h0);

      // reset release: three fetches
      reset = 1'b0;
      tick(); tick(); tick();
      chk("rel_pc",    32'(ifid_curr_pc), 32'h8);
      chk("rel_instr", ifid_curr_instr,   32'hA8);
      chk("rel_valid", 32'(ifid_valid),   32'h1);
      chk("rel_addr",  32'(imem_addr),    32'hC);

      // stall for two cycles at PC=12
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("stall_ifid_pc", 32'(ifid_curr_pc), 32'h8);
         chk("stall_addr",    32'(imem_addr),    32'hC);
      end
      stall = 1'b0;
      tick();
      chk("after_stall_pc",    32'(ifid_curr_pc), 32'hC);
      chk("after_stall_instr", ifid_curr_instr,   32'hAC);

      // redirect with stall, unaligned target
      redirect = 1'b1; redirect_pc = 9'h047; stall = 1'b1;
      tick();
      chk("redir_addr",  32'(imem_addr),    32'h44);
      chk("redir_instr", ifid_curr_instr,   32'h13);
      chk("redir_valid", 32'(ifid_valid),   32'h0);
      chk("redir_pc",    32'(ifid_curr_pc), 32'h0);

      // wrap from 508
      stall = 1'b0; redirect_pc = 9'h1FC;
      tick();
      chk("wrap_setup", 32'(imem_addr), 32'h1FC);
      redirect = 1'b0;
      tick();
      chk("wrap_ifid_pc", 32'(ifid_curr_pc), 32'h1FC);
      chk("wrap_addr",    32'(imem_addr),    32'h0);

      // counters: 5 fetches, 2 redirects, 1 stall
      reset = 1'b1; tick(); reset = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      redirect = 1'b1; redirect_pc = 9'h047;
      tick(); tick();
      redirect = 1'b0; stall = 1'b1;
      tick();
      stall = 1'b0;
`ifdef IF_FETCH_PERF_CNT_EN
      chk("cnt_fetch",  fetch_cnt,  32'd5);
      chk("cnt_bubble", bubble_cnt, 32'd2);
`else
      chk("cnt_fetch",  fetch_cnt,  32'd0);
      chk("cnt_bubble", bubble_cnt, 32'd0);
`endif

      // halt together with redirect
      halt = 1'b1; redirect = 1'b1; redirect_pc = 9'h080;
      tick();
      chk("halt_flag", 32'(halted),    32'h1);
      chk("halt_addr", 32'(imem_addr), 32'h44);
      halt = 1'b0;
      for (int i = 0; i < 10; i++) begin
         stall = 1'($urandom_range(0, 1)); redirect = 1'($urandom_range(0, 1));
         halt  = 1'($urandom_range(0, 1));
         tick();
         chk("halted_hold",  32'(halted),     32'h1);
         chk("halted_addr",  32'(imem_addr),  32'h44);
         chk("halted_valid", 32'(ifid_valid), 32'h0);
      end
      halt = 1'b0; redirect = 1'b0; stall = 1'b0;
      reset = 1'b1;
      tick();
      chk("halt_rst_addr", 32'(imem_addr), 32'h0);
      chk("halt_rst_flag", 32'(halted),    32'h0);
      reset = 1'b0;

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         reset       = ($urandom_range(0, halted ? 5 : 60) == 0);
         halt        = ($urandom_range(0, 40) == 0);
         redirect    = ($urandom_range(0, 4) == 0);
         stall       = ($urandom_range(0, 3) == 0);
         redirect_pc = PC_W'($urandom);
         tick();
      end
      reset = 1'b0; halt = 1'b0; redirect = 1'b0; stall = 1'b0;
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL take parameter PC_W, default 9: PC and instruction-memory byte-address width.
REQ-002 SHALL take parameter INSTR_W, default 32: instruction width.
REQ-003 SHALL take parameter RESET_PC, default 0: PC value loaded at reset.
REQ-004 SHALL provide clk  in  1: the only clock; all state updates on the rising edge.
REQ-005 SHALL provide reset  in  1: synchronous, active-high reset.
REQ-006 SHALL provide stall  in  1: load-use hold request from hazard detection.
REQ-007 SHALL provide redirect  in  1: taken branch/jal/jalr flush request from EX.
REQ-008 SHALL provide redirect_pc  in  PC_W: redirect target byte address.
REQ-009 SHALL provide halt  in  1: Halt control bit of the ID/EX register.
REQ-010 SHALL provide imem_addr  out  PC_W: combinational instruction-memory read address.
REQ-011 SHALL provide imem_rdata  in  INSTR_W: combinational read data for imem_addr.
REQ-012 SHALL provide ifid_curr_pc  out  PC_W: Curr_Pc field of the IF/ID register.
REQ-013 SHALL provide ifid_curr_instr  out  INSTR_W: Curr_Instr field of the IF/ID register.
REQ-014 SHALL provide ifid_valid  out  1: IF/ID holds a real instruction, not a bubble.
REQ-015 SHALL provide halted  out  1: fetch stopped permanently until reset.
REQ-016 SHALL provide fetch_cnt  out  32: count of valid instructions loaded into IF/ID.
REQ-017 SHALL provide bubble_cnt  out  32: count of bubbles inserted into IF/ID.

Function
REQ-018 SHALL hold a PC register and drive imem_addr = PC every cycle.
REQ-019 SHALL use a two-state FSM, RUN and HALTED; reset enters RUN.
REQ-020 SHALL apply per-cycle priority reset > halt > redirect > stall > normal.
REQ-021 SHALL, on normal in RUN: PC <= PC+4 mod 2^PC_W; IF/ID <= {PC, imem_rdata}; ifid_valid <= 1.
REQ-022 SHALL, on stall in RUN: hold PC, ifid_curr_pc, ifid_curr_instr and ifid_valid unchanged.
REQ-023 SHALL, on redirect in RUN: PC <= redirect_pc with bits [1:0] forced 0; IF/ID <= bubble; redirect overrides a simultaneous stall.
REQ-024 SHALL encode a bubble as ifid_curr_pc=0, ifid_curr_instr=32'h0000_0013 (addi x0,x0,0), ifid_valid=0.
REQ-025 SHALL, on halt in RUN: move to HALTED; hold PC; IF/ID <= bubble; ignore a same-cycle redirect or stall.
REQ-026 SHALL, in HALTED: hold PC; keep IF/ID as a bubble; assert halted; ignore stall, redirect and halt; leave HALTED only on reset.
REQ-027 SHALL wrap PC from 2^PC_W-4 to 0 with no error indication.
REQ-028 SHALL produce IF/ID outputs only from registers, giving one cycle of latency from imem_rdata.

Reset
REQ-029 SHALL, when reset is high at an edge, set PC=RESET_PC, state=RUN, IF/ID=bubble, halted=0, fetch_cnt=0, bubble_cnt=0, regardless of other inputs.
REQ-030 SHALL, on reset mid-stall, mid-redirect or in HALTED, discard the pending operation; the first fetch after reset deasserts uses RESET_PC.

Configuration
REQ-031 SHALL, with macro IF_FETCH_PERF_CNT_EN defined, increment fetch_cnt on each REQ-021 load and bubble_cnt on each REQ-023/REQ-025 bubble, both saturating at 2^32-1.
REQ-032 SHALL, without IF_FETCH_PERF_CNT_EN, keep the fetch_cnt and bubble_cnt ports but tie them to 0, with no counter flops.

Verification
REQ-033 SHALL cover reset release with imem returning 0xA0+PC -> after 3 edges ifid_curr_pc=8, ifid_curr_instr=0xA8, ifid_valid=1.
REQ-034 SHALL cover stall held 2 cycles at PC=12 -> IF/ID keeps PC 8 for both cycles; the next fetch is PC 12.
REQ-035 SHALL cover redirect with redirect_pc=0x47 and stall both high -> next imem_addr=0x44; IF/ID=bubble with instr 0x00000013 and valid 0.
REQ-036 SHALL cover halt together with redirect -> halted=1; PC frozen; IF/ID stays a bubble for 10 cycles; reset then restores PC=RESET_PC.
REQ-037 SHALL cover wrap: PC=508 normal fetch -> next PC=0; ifid_curr_pc=508.
REQ-038 SHALL cover counters, with IF_FETCH_PERF_CNT_EN: 5 fetches, 2 redirects, 1 stall -> fetch_cnt=5, bubble_cnt=2; without the macro -> both read 0.
